// File: rtl/sparserdes_pkg.sv
// Shared definitions for the sparse serial link: receiver states, line levels and frame sizing.
package sparserdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rx_state_e;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;

    function automatic int unsigned frame_len(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/sparse_frame_decoder_fifo.sv
// Small synchronous address FIFO with a register-file head; a pop in the same cycle
// always makes room for a push, even when full.
module addr_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_drained,
    output logic             o_drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_head    = r_mem[r_rd];
    assign o_empty   = (r_count == '0);
    // Empty after this edge, given that no push arrives alongside the pop.
    assign o_drained = o_empty || ((r_count == ONE_CNT) && w_pop && !i_push);
    assign o_drop    = i_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sparse_frame_decoder.sv
// Sparse link receiver: finds a start bit, samples one frame of occupancy bits and
// emits the index of every set bit over a valid/ready address stream.
module sparse_frame_decoder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              bitstream_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    import sparserdes_pkg::*;

    localparam int unsigned       FRAME_LEN = frame_len(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);

    rx_state_e         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_overflow;

    logic w_push;
    logic w_empty;
    logic w_drained;
    logic w_drop;

    assign w_push = enable && (r_state == RECV) && bitstream_in;

    addr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_push    (w_push),
        .i_data    (r_cnt),
        .i_pop     (addr_ready),
        .o_head    (addr_out),
        .o_empty   (w_empty),
        .o_drained (w_drained),
        .o_drop    (w_drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (enable) begin
                unique case (r_state)
                    IDLE: begin
                        if (bitstream_in == START_LEVEL) begin
                            r_state    <= RECV;
                            r_cnt      <= '0;
                            r_overflow <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // Lookahead lets the last pop and the move to DONE share an edge.
                    DRAIN: begin
                        if (w_drained) begin
                            r_state <= DONE;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign addr_valid = !w_empty;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_sparse_frame_decoder.sv
// Bench for sparse_frame_decoder: two instances (FIFO depth 4 and 2) share stimulus and are
// checked each cycle against a queue-based frame model plus directed literal expectations.
module tb_sparse_frame_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic enable;
    logic bitstream_in;
    logic addr_ready;

    logic [2:0] d_addr  [2];
    logic       d_valid [2];
    logic       d_busy  [2];
    logic       d_done  [2];
    logic       d_ovf   [2];

    sparse_frame_decoder #(.ADDR_W(3), .FIFO_DEPTH(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bitstream_in (bitstream_in),
        .addr_out     (d_addr[0]),
        .addr_valid   (d_valid[0]),
        .addr_ready   (addr_ready),
        .busy         (d_busy[0]),
        .done         (d_done[0]),
        .overflow     (d_ovf[0])
    );

    sparse_frame_decoder #(.ADDR_W(3), .FIFO_DEPTH(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bitstream_in (bitstream_in),
        .addr_out     (d_addr[1]),
        .addr_valid   (d_valid[1]),
        .addr_ready   (addr_ready),
        .busy         (d_busy[1]),
        .done         (d_done[1]),
        .overflow     (d_ovf[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_cyc = 0;
    bit live     = 1'b0;
    bit tog      = 1'b0;

    // Model: phase 0 idle, 1 receiving, 2 draining, 3 done; buffered addresses in m_q.
    int m_ph  [2];
    int m_cnt [2];
    int m_len [2];
    bit m_ovf [2];
    int m_q   [2][8];

    int got      [2][16];
    int got_n    [2];
    int done_n   [2];
    int busy_n   [2];
    int valid_n  [2];
    int done_cyc [2];

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        int dep;
        bit pop;
        bit push;
        int idx;
        int nph;
        dep  = (k == 0) ? 4 : 2;
        if (!rst_n) begin
            m_ph[k]  = 0;
            m_cnt[k] = 0;
            m_len[k] = 0;
            m_ovf[k] = 1'b0;
            return;
        end
        pop  = (m_len[k] > 0) && (addr_ready == 1'b1);
        push = 1'b0;
        idx  = m_cnt[k];
        nph  = m_ph[k];
        if (enable) begin
            case (m_ph[k])
                0: if (bitstream_in) begin
                    nph      = 1;
                    m_cnt[k] = 0;
                    m_ovf[k] = 1'b0;
                end
                1: begin
                    if (bitstream_in) begin
                        if (m_len[k] < dep || pop) push = 1'b1;
                        else m_ovf[k] = 1'b1;
                    end
                    if (m_cnt[k] == 7) nph = 2;
                    else m_cnt[k]++;
                end
                2: if (m_len[k] - int'(pop) == 0) nph = 3;
                default: nph = 0;
            endcase
        end
        if (pop) begin
            for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i + 1];
            m_len[k]--;
        end
        if (push) begin
            m_q[k][m_len[k]] = idx;
            m_len[k]++;
        end
        m_ph[k] = nph;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (live && rst_n && d_valid[k] === 1'b1 && addr_ready && got_n[k] < 16) begin
                    got[k][got_n[k]] = int'(d_addr[k]);
                    got_n[k]++;
                end
                model_step(k);
            end
            if (!rst_n) live = 1'b1;
            #1;
            if (live) begin
                for (int k = 0; k < 2; k++) begin
                    chk("valid", k, d_valid[k], m_len[k] > 0);
                    if (m_len[k] > 0) chk("addr", k, d_addr[k], m_q[k][0]);
                    chk("busy", k, d_busy[k], m_ph[k] != 0);
                    chk("done", k, d_done[k], m_ph[k] == 3);
                    chk("overflow", k, d_ovf[k], m_ovf[k]);
                    if (d_done[k] === 1'b1) begin
                        done_n[k]++;
                        done_cyc[k] = cyc;
                    end
                    if (d_busy[k] === 1'b1) busy_n[k]++;
                    if (d_valid[k] === 1'b1) valid_n[k]++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (tog) addr_ready = ~addr_ready;
    endtask

    task automatic clear();
        for (int k = 0; k < 2; k++) begin
            got_n[k]   = 0;
            done_n[k]  = 0;
            busy_n[k]  = 0;
            valid_n[k] = 0;
            for (int j = 0; j < 16; j++) got[k][j] = -1;
        end
    endtask

    // Start bit, then bits[7-i] as data index i; optional 3-cycle enable stall after index stall_after.
    task automatic send_frame(input logic [7:0] bits, input int stall_after);
        bitstream_in = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            bitstream_in = bits[7 - i];
            if (i == 7) last_cyc = cyc;
            step();
            if (i == stall_after) begin
                enable       = 1'b0;
                bitstream_in = 1'b1;
                repeat (3) step();
                enable = 1'b1;
            end
        end
        bitstream_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((d_busy[0] !== 1'b0 || d_busy[1] !== 1'b0) && n < 60) begin
            step();
            n++;
        end
        chk(name, 0, n < 60, 1);
    endtask

    // mask bit j set means address j expected; events must arrive in ascending order.
    task automatic chk_events(input string name, input int k, input logic [7:0] mask);
        int p;
        p = 0;
        for (int j = 0; j < 8; j++) begin
            if (mask[j]) begin
                chk(name, k, got[k][p], j);
                p++;
            end
        end
        chk(name, k, got_n[k], p);
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk(name, k, d_valid[k], 0);
            chk(name, k, d_addr[k], 0);
            chk(name, k, d_busy[k], 0);
            chk(name, k, d_done[k], 0);
            chk(name, k, d_ovf[k], 0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b1;
        bitstream_in = 1'b0;
        addr_ready   = 1'b1;
        clear();
        step();
        step();
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        step();

        // Events 0,3,7 with ready high; done lands 2 cycles after the last data bit.
        clear();
        send_frame(8'b10010001, -1);
        wait_idle("t1_idle");
        for (int k = 0; k < 2; k++) begin
            chk_events("t1_events", k, 8'h89);
            chk("t1_done_count", k, done_n[k], 1);
            chk("t1_done_delay", k, done_cyc[k] - last_cyc, 2);
            chk("t1_overflow", k, d_ovf[k], 0);
        end

        // Consumer stalled: depth-2 instance keeps 0,1 and drops 2; depth-4 keeps all three.
        clear();
        addr_ready = 1'b0;
        send_frame(8'b11100000, -1);
        repeat (3) step();
        chk("t2_ovf_depth2", 1, d_ovf[1], 1);
        chk("t2_ovf_depth4", 0, d_ovf[0], 0);
        chk("t2_held_addr", 1, d_addr[1], 0);
        chk("t2_busy_held", 1, d_busy[1], 1);
        addr_ready = 1'b1;
        wait_idle("t2_idle");
        chk_events("t2_events", 0, 8'h07);
        chk_events("t2_events", 1, 8'h03);
        chk("t2_done_count", 0, done_n[0], 1);
        chk("t2_done_count", 1, done_n[1], 1);
        chk("t2_ovf_sticky", 1, d_ovf[1], 1);

        // All-zero frame.
        clear();
        send_frame(8'b00000000, -1);
        wait_idle("t3_idle");
        for (int k = 0; k < 2; k++) begin
            chk("t3_busy_cycles", k, busy_n[k], 10);
            chk("t3_done_count", k, done_n[k], 1);
            chk("t3_no_valid", k, valid_n[k], 0);
        end

        // All ones with ready toggling; depth 4 rides through a full-with-pop edge.
        clear();
        tog = 1'b1;
        send_frame(8'b11111111, -1);
        wait_idle("t4_idle");
        tog        = 1'b0;
        addr_ready = 1'b1;
        chk_events("t4_events", 0, 8'hFF);
        chk("t4_overflow", 0, d_ovf[0], 0);
        chk("t4_done_count", 0, done_n[0], 1);

        // Enable stall after index 2 with ones on the wire: they must be ignored.
        clear();
        step();
        send_frame(8'b10100110, 2);
        wait_idle("t5_idle");
        for (int k = 0; k < 2; k++) begin
            chk_events("t5_events", k, 8'h65);
            chk("t5_done_count", k, done_n[k], 1);
        end

        // Reset at data index 4 with pending events, then a fresh frame.
        clear();
        addr_ready   = 1'b0;
        bitstream_in = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bitstream_in = 1'b1;
            step();
        end
        rst_n        = 1'b0;
        bitstream_in = 1'b1;
        step();
        chk_all_zero("t6_abort");
        rst_n        = 1'b1;
        bitstream_in = 1'b0;
        step();
        step();
        chk("t6_no_done", 0, done_n[0], 0);
        chk("t6_no_done", 1, done_n[1], 0);
        addr_ready = 1'b1;
        send_frame(8'b01000000, -1);
        wait_idle("t6_idle");
        for (int k = 0; k < 2; k++) begin
            chk_events("t6_events", k, 8'h02);
            chk("t6_done_count", k, done_n[k], 1);
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sparse_frame_decoder.md
Name: sparse_frame_decoder

Overview:
Receive side of the sparse serial link. Watches a single-wire bitstream for a start bit, then samples one fixed-length frame of occupancy bits. It emits the index (address) of every set bit as an address event over a valid/ready handshake. It sits downstream of the sparse serializer and turns the wire back into an address stream for the consuming logic.

Parameters:
ADDR_W, 8, address width; frame length FRAME_LEN = 2**ADDR_W bits.
FIFO_DEPTH, 4, number of address entries buffered between bit sampling and the consumer; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst_n  input  1  synchronous, active-low reset.
enable  input  1  clock-enable for reception; low freezes the receive state and bit counter.
bitstream_in  input  1  serial line: idle 0, start bit 1, then FRAME_LEN data bits, index 0 first.
addr_out  output  ADDR_W  address of the oldest buffered set bit.
addr_valid  output  1  addr_out holds a valid event.
addr_ready  input  1  consumer accepts the event when addr_valid && addr_ready at a clock edge.
busy  output  1  high from the cycle after the start bit until done is asserted.
done  output  1  one-cycle pulse: frame fully received and all its events consumed.
overflow  output  1  sticky: at least one event in the current/last frame was dropped.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, bit counter 0, FIFO empty. addr_out=0, addr_valid=0, busy=0, done=0, overflow=0. Reset mid-frame aborts the frame and discards buffered events. No done is emitted for an aborted frame.
- States: IDLE, RECV, DRAIN, DONE. Sampling happens only on edges with enable=1; with enable=0 the state and counter hold. The output handshake still operates while enable=0.
- IDLE: bitstream_in=1 sampled -> RECV, counter<=0, overflow<=0. Otherwise stay.
- RECV: each sampled bit is data index = counter. If the bit is 1, push counter into the FIFO. At counter==FRAME_LEN-1 -> DRAIN, else counter+1. Counter width is ADDR_W with no wrap inside a frame. The start bit of the next frame is never searched for during RECV.
- DRAIN: wait until the FIFO is empty, then -> DONE. If already empty on entry, spend exactly one DRAIN cycle.
- DONE: done=1 for exactly one cycle -> IDLE. The next start bit may be sampled on the cycle after DONE.
- busy = (state != IDLE). done is asserted only in DONE.
- FIFO timing: a push at edge t gives addr_valid=1 from t (registered outputs, visible the cycle after the sampling cycle). Events come out in ascending address order.
- Pop on addr_valid && addr_ready. addr_out is stable while addr_valid=1 and addr_ready=0.
- Simultaneous push and pop: always allowed, including when full. The pop frees a slot and the push is accepted.
- Full without a pop when a 1 is sampled: the event is dropped and overflow<=1. overflow stays set until the next start bit or reset.
- All-zero frame: no events; done occurs 2 cycles after the last data bit (DRAIN, then DONE).

Decomposition:
- Package sparserdes_pkg holds:
  - the state enum typedef (IDLE/RECV/DRAIN/DONE);
  - the FRAME_LEN derivation function;
  - the IDLE_LEVEL/START_LEVEL constants shared with the serializer.
- Sub-module addr_fifo (parameters WIDTH, DEPTH):
  - synchronous FIFO with push/pop/full/empty and a registered head;
  - the push-when-full-with-pop rule lives there.
- Top FSM plus counter: roughly 150 lines; FIFO: roughly 100 lines.

Test Plan:
- ADDR_W=3, addr_ready=1, send start then bits 10010001 (index 0 first) -> events 0, 3, 7 each valid one cycle after sampling; done one pulse 2 cycles after the last bit; overflow=0.
- ADDR_W=3, FIFO_DEPTH=2, addr_ready=0, frame 11100000 -> events 0, 1 held, overflow=1. Then addr_ready=1 -> 0, 1 delivered, then done.
- Frame 00000000 -> no addr_valid; busy high for 8+2 cycles; single done pulse.
- Frame 11111111 with addr_ready toggling 1/0 and FIFO_DEPTH=4 -> all 0..7 delivered in order, addr_out stable while stalled, overflow=0.
- enable low for 3 cycles mid-frame after index 2 -> counter holds; bits presented during the stall are ignored; the remaining addresses are still correct.
- rst_n=0 at index 4 of a frame with pending events -> all outputs 0 next cycle, no done. A fresh frame 01000000 then yields only event 1.
